// File: rtl/aon_pkg.sv
// -----------------------------------------------------------------------------
// aon_pkg
// Shared definitions for the always-on (AON) power domain: the power-sequencer
// state encoding, the default RTC width, and the settle-counter load helper.
// The AON top level reuses these, so keep encodings stable.
// -----------------------------------------------------------------------------
package aon_pkg;

    // Default width of the ripple RTC and the alarm register.
    localparam int unsigned RTC_W_DEF = 48;

    // Power-sequencer states.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PD_IO  = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_PU_SYS = 2'd3
    } pwr_state_e;

    // Plain-vector aliases of the enum, for logic that carries the state as
    // a bare logic [1:0] (legacy blocks compare against these).
    localparam logic [1:0] S_RUN    = 2'(ST_RUN);
    localparam logic [1:0] S_PD_IO  = 2'(ST_PD_IO);
    localparam logic [1:0] S_SLEEP  = 2'(ST_SLEEP);
    localparam logic [1:0] S_PU_SYS = 2'(ST_PU_SYS);

    // The dwell counter counts down to zero inclusive, so it is loaded with
    // one less than the wanted dwell in cycles.
    function automatic logic [7:0] settle_load(input int unsigned settle);
        return 8'(settle - 1);
    endfunction

endpackage : aon_pkg

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Parameterised-width two-flop synchroniser with asynchronous active-low reset.
// Each bit is synchronised independently; multi-bit coherence is the caller's
// problem.
//
// Ports:
//   clk   in  1  destination clock
//   rstb  in  1  asynchronous active-low reset (flops clear to 0)
//   d     in  W  asynchronous input
//   q     out W  synchronised output, two clk edges after d
// -----------------------------------------------------------------------------
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] meta_d;
    logic [W-1:0] sync_q;
    logic [W-1:0] sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value; blocking here would collapse the two stages into one.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : sync2

// File: rtl/aon_pwr_seq.sv
// -----------------------------------------------------------------------------
// aon_pwr_seq
// Always-on power sequencer. Takes a coherent snapshot of the asynchronous
// ripple RTC, compares it with a programmable alarm, and sequences the IO and
// system power-down controls: sleep request -> pd_io, SETTLE cycles, pd_sys;
// wake (alarm or wake pin) -> release pd_sys, SETTLE cycles, release pd_io.
//
// Parameters:
//   RTC_W   RTC / alarm width
//   SETTLE  cycles between the pd_io and pd_sys edges (legal 1..255)
//
// Ports:
//   clk           in   1      always-on clock (>= 4x the RTC tick rate)
//   rstb          in   1      asynchronous active-low reset
//   rtc           in   RTC_W  ripple RTC, asynchronous, bits settle unevenly
//   wake_pin      in   1      asynchronous wake, rising-edge active
//   sleep_req     in   1      sleep request level, honoured only in RUN
//   alarm_we      in   1      load alarm_wdata into the alarm register
//   alarm_wdata   in   RTC_W  alarm value
//   alarm_en      in   1      enable alarm compare
//   irq_clr       in   1      clear alarm_irq (a simultaneous set wins)
//   rtc_snap      out  RTC_W  coherent RTC snapshot
//   rtc_snap_vld  out  1      one-cycle pulse when rtc_snap changes
//   alarm_irq     out  1      sticky alarm flag
//   pd_io         out  1      IO domain power-down
//   pd_sys        out  1      system domain power-down
//   busy          out  1      high whenever the sequencer is not in RUN
// -----------------------------------------------------------------------------
module aon_pwr_seq
    import aon_pkg::*;
#(
    parameter int unsigned RTC_W  = RTC_W_DEF,
    parameter int unsigned SETTLE = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [RTC_W-1:0] rtc,
    input  logic             wake_pin,
    input  logic             sleep_req,
    input  logic             alarm_we,
    input  logic [RTC_W-1:0] alarm_wdata,
    input  logic             alarm_en,
    input  logic             irq_clr,
    output logic [RTC_W-1:0] rtc_snap,
    output logic             rtc_snap_vld,
    output logic             alarm_irq,
    output logic             pd_io,
    output logic             pd_sys,
    output logic             busy
);

    localparam logic [7:0] SETTLE_LD = settle_load(SETTLE);

    // ---------------------------------------------------------------- signals
    logic [RTC_W-1:0] rtc_s;
    logic [RTC_W-1:0] rtc_p_q,        rtc_p_d;
    logic [RTC_W-1:0] rtc_snap_q,     rtc_snap_d;
    logic             rtc_snap_vld_q, rtc_snap_vld_d;
    logic [RTC_W-1:0] alarm_q,        alarm_d;
    logic             alarm_irq_q,    alarm_irq_d;

    logic             wake_s;
    logic             wake_s_q,       wake_s_d;
    logic             wake_pend_q,    wake_pend_d;

    logic [1:0]       state_q,        state_d;
    logic [7:0]       cnt_q,          cnt_d;
    logic             pd_io_q,        pd_io_d;
    logic             pd_sys_q,       pd_sys_d;
    logic             busy_q,         busy_d;

    logic             snap_upd;
    logic             wake_rise;
    logic             wake_evt;
    logic             wake_clr;

    // ---------------------------------------------------------- synchronisers
    sync2 #(.W(RTC_W)) u_sync_rtc (
        .clk  (clk),
        .rstb (rstb),
        .d    (rtc),
        .q    (rtc_s)
    );

    sync2 #(.W(1)) u_sync_wake (
        .clk  (clk),
        .rstb (rstb),
        .d    (wake_pin),
        .q    (wake_s)
    );

    // ------------------------------------------------------ RTC + alarm path
    // NOTE: every signal written in an always_comb gets a value on every path
    // (here by straight assignment, in the FSM by defaults first); a path that
    // leaves one unassigned infers a latch.
    always_comb begin
        rtc_p_d = rtc_s;

        // Two identical consecutive synchronised samples mean the ripple has
        // settled; a sample caught mid-ripple never matches its neighbour and
        // is dropped.
        snap_upd       = (rtc_s == rtc_p_q) && (rtc_s != rtc_snap_q);
        rtc_snap_d     = snap_upd ? rtc_s : rtc_snap_q;
        rtc_snap_vld_d = snap_upd;

        alarm_d = alarm_we ? alarm_wdata : alarm_q;

        // >= rather than == so a snapshot that jumps past the alarm value
        // still fires. Set has priority over clear.
        if (alarm_en && (rtc_snap_q >= alarm_q)) begin
            alarm_irq_d = 1'b1;
        end else if (irq_clr) begin
            alarm_irq_d = 1'b0;
        end else begin
            alarm_irq_d = alarm_irq_q;
        end
    end

    // --------------------------------------------------------- sequencer FSM
    assign wake_evt = alarm_irq_q | wake_pend_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_RUN: begin
                if (sleep_req) begin
                    state_d = S_PD_IO;
                    cnt_d   = SETTLE_LD;
                end
            end
            S_PD_IO: begin
                if (wake_evt) begin
                    state_d = S_RUN;
                end else if (cnt_q == 8'd0) begin
                    state_d = S_SLEEP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SLEEP: begin
                if (wake_evt) begin
                    state_d = S_PU_SYS;
                    cnt_d   = SETTLE_LD;
                end
            end
            S_PU_SYS: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state and never glitch.
        pd_io_d  = (state_d != S_RUN);
        pd_sys_d = (state_d == S_SLEEP);
        busy_d   = (state_d != S_RUN);

        // A pin edge that coincides with entry to PU_SYS / RUN is absorbed by
        // the wake being serviced.
        wake_s_d  = wake_s;
        wake_rise = wake_s & ~wake_s_q;
        wake_clr  = (state_d != state_q) &&
                    ((state_d == S_PU_SYS) || (state_d == S_RUN));
        if (wake_clr) begin
            wake_pend_d = 1'b0;
        end else if (wake_rise) begin
            wake_pend_d = 1'b1;
        end else begin
            wake_pend_d = wake_pend_q;
        end
    end

    // ------------------------------------------------------------- registers
    // NOTE: the alarm register resets to all-ones rather than zero so an
    // enabled compare cannot fire before software has programmed a value.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rtc_p_q        <= '0;
            rtc_snap_q     <= '0;
            rtc_snap_vld_q <= 1'b0;
            alarm_q        <= '1;
            alarm_irq_q    <= 1'b0;
            wake_s_q       <= 1'b0;
            wake_pend_q    <= 1'b0;
            state_q        <= S_RUN;
            cnt_q          <= 8'd0;
            pd_io_q        <= 1'b0;
            pd_sys_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            rtc_p_q        <= rtc_p_d;
            rtc_snap_q     <= rtc_snap_d;
            rtc_snap_vld_q <= rtc_snap_vld_d;
            alarm_q        <= alarm_d;
            alarm_irq_q    <= alarm_irq_d;
            wake_s_q       <= wake_s_d;
            wake_pend_q    <= wake_pend_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pd_io_q        <= pd_io_d;
            pd_sys_q       <= pd_sys_d;
            busy_q         <= busy_d;
        end
    end

    assign rtc_snap     = rtc_snap_q;
    assign rtc_snap_vld = rtc_snap_vld_q;
    assign alarm_irq    = alarm_irq_q;
    assign pd_io        = pd_io_q;
    assign pd_sys       = pd_sys_q;
    assign busy         = busy_q;

endmodule : aon_pwr_seq
